// File: rtl/ieee_square_iter.sv
`default_nettype none
// ============================================================================
// Module      : ieee_square_iter
// Description : Multi-cycle IEEE 754 squarer (result = x*x). Radix-2
//               shift-add significand multiplier, round-to-nearest-even,
//               subnormals flushed to zero. Valid/ready on both sides;
//               special operands bypass the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module ieee_square_iter #(
    parameter  int EXP_WIDTH  = 8,
    parameter  int MANT_WIDTH = 23,
    localparam int DATA_WIDTH = 1 + EXP_WIDTH + MANT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] operand_x_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int c_sig_w  = MANT_WIDTH + 1;
    localparam int c_prod_w = 2 * MANT_WIDTH + 2;
    localparam int c_ew2    = EXP_WIDTH + 2;

    localparam logic [c_ew2-1:0]        c_bias    = c_ew2'((1 << (EXP_WIDTH - 1)) - 1);
    localparam logic signed [c_ew2-1:0] c_exp_max = c_ew2'((1 << EXP_WIDTH) - 1);
    localparam logic [c_sig_w-1:0]      c_cnt_ld  = c_sig_w'(c_sig_w);
    localparam logic [c_sig_w-1:0]      c_cnt_one = c_sig_w'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_norm = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [DATA_WIDTH-1:0] c_qnan = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] c_pinf = {1'b0, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [c_sig_w-1:0]    r_sig;
    logic [c_sig_w-1:0]    r_mplr;
    logic [c_prod_w-1:0]   r_prod;
    logic [c_sig_w-1:0]    r_cnt;
    logic [EXP_WIDTH-1:0]  r_exp;
    logic [DATA_WIDTH-1:0] r_result;

    // ---------------- operand classification ----------------
    logic [EXP_WIDTH-1:0]  w_in_exp;
    logic [MANT_WIDTH-1:0] w_in_frac;
    logic                  w_exp_ones;
    logic                  w_exp_zero;
    logic                  w_special;
    logic [DATA_WIDTH-1:0] w_special_res;
    logic                  w_unused_sign;

    assign w_in_exp      = operand_x_i[DATA_WIDTH-2 -: EXP_WIDTH];
    assign w_in_frac     = operand_x_i[MANT_WIDTH-1:0];
    assign w_unused_sign = operand_x_i[DATA_WIDTH-1];  // squaring always yields sign 0
    assign w_exp_ones    = &w_in_exp;
    assign w_exp_zero    = ~|w_in_exp;
    assign w_special     = w_exp_ones | w_exp_zero;

    // Special results: NaN -> canonical qNaN, Inf -> +Inf, zero/subnormal -> +0
    always_comb begin
        w_special_res = '0;
        if (w_exp_ones && (|w_in_frac)) begin
            w_special_res = c_qnan;
        end else if (w_exp_ones) begin
            w_special_res = c_pinf;
        end
    end

    // ---------------- shift-add iteration ----------------
    logic [c_sig_w-1:0] w_addend;
    logic [c_sig_w:0]   w_sum;

    assign w_addend = r_mplr[0] ? r_sig : '0;
    assign w_sum    = {1'b0, r_prod[c_prod_w-1 -: c_sig_w]} + {1'b0, w_addend};

    // ---------------- normalise and round ----------------
    logic                     w_shift;
    logic [MANT_WIDTH-1:0]    w_mant;
    logic                     w_guard;
    logic                     w_sticky;
    logic                     w_round_up;
    logic [MANT_WIDTH:0]      w_mant_rnd;
    logic                     w_carry;
    logic [c_ew2-1:0]         w_exp_adj;
    logic signed [c_ew2-1:0]  w_exp_biased;
    logic [DATA_WIDTH-1:0]    w_norm_res;

    // Product is in [1,4); its top bit selects whether the field sits one bit higher
    assign w_shift    = r_prod[c_prod_w-1];
    assign w_mant     = w_shift ? r_prod[2*MANT_WIDTH -: MANT_WIDTH]
                                : r_prod[2*MANT_WIDTH-1 -: MANT_WIDTH];
    assign w_guard    = w_shift ? r_prod[MANT_WIDTH] : r_prod[MANT_WIDTH-1];
    assign w_sticky   = w_shift ? (|r_prod[MANT_WIDTH-1:0]) : (|r_prod[MANT_WIDTH-2:0]);
    assign w_round_up = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_rnd = {1'b0, w_mant} + {{MANT_WIDTH{1'b0}}, w_round_up};
    // A rounding carry leaves the fraction all-zero, which is already renormalised
    assign w_carry    = w_mant_rnd[MANT_WIDTH];
    assign w_exp_adj  = {{(c_ew2-1){1'b0}}, w_shift} + {{(c_ew2-1){1'b0}}, w_carry};
    // Biased result exponent = 2*e - bias (+shift, +carry), in two's complement
    assign w_exp_biased = {1'b0, r_exp, 1'b0} - c_bias + w_exp_adj;

    // Range check then pack the normal result
    always_comb begin
        w_norm_res = {1'b0, w_exp_biased[EXP_WIDTH-1:0], w_mant_rnd[MANT_WIDTH-1:0]};
        if (w_exp_biased >= c_exp_max) begin
            w_norm_res = c_pinf;
        end else if (w_exp_biased <= 0) begin
            w_norm_res = '0;
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (valid_i) w_state_nxt = w_special ? c_st_done : c_st_mul;
            c_st_mul:  if (r_cnt == c_cnt_one) w_state_nxt = c_st_norm;
            c_st_norm: w_state_nxt = c_st_done;
            c_st_done: if (ready_i) w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // Datapath: operand capture, one multiplier step per MUL cycle, result write
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sig    <= '0;
            r_mplr   <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_exp    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (valid_i) begin
                        if (w_special) begin
                            r_result <= w_special_res;
                        end else begin
                            r_sig  <= {1'b1, w_in_frac};
                            r_mplr <= {1'b1, w_in_frac};
                            r_prod <= '0;
                            r_cnt  <= c_cnt_ld;
                            r_exp  <= w_in_exp;
                        end
                    end
                end
                c_st_mul: begin
                    r_prod <= {w_sum, r_prod[MANT_WIDTH:1]};
                    r_mplr <= r_mplr >> 1;
                    r_cnt  <= r_cnt - c_cnt_one;
                end
                c_st_norm: r_result <= w_norm_res;
                default: ;
            endcase
        end
    end

    assign ready_o  = (r_state == c_st_idle);
    assign valid_o  = (r_state == c_st_done);
    assign result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_ieee_square_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ieee_square_iter
// Description : Self-checking scoreboard bench for ieee_square_iter (fp32).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ieee_square_iter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] operand_x_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] result_o;
    logic        valid_o;
    logic        ready_i = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    int          acc_q[$];
    int          lat_q[$];
    logic        r_seen = 1'b0;

    ieee_square_iter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .operand_x_i (operand_x_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .result_o    (result_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i)
    );

    always #5 clk_i = ~clk_i;

    // Cycle counter for latency measurement
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: on each rising valid_o compare result and latency
    always @(negedge clk_i) begin : mon
        logic [31:0] e;
        int          a;
        int          l;
        if (rst_i) begin
            r_seen = 1'b0;
        end else if (valid_o && !r_seen) begin
            r_seen = 1'b1;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(valid_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                l = lat_q.pop_front();
                check("result", result_o, e);
                check("latency", 32'(cyc - a), 32'(l));
            end
        end
        if (!valid_o) r_seen = 1'b0;
    end

    task automatic accept(input logic [31:0] x, input logic [31:0] e, input int lat);
        int n = 0;
        @(negedge clk_i);
        operand_x_i = x;
        valid_i     = 1'b1;
        while (!ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("accept_ready_o", 32'(ready_o), 32'd1);
        if (ready_o) begin
            exp_q.push_back(e);
            acc_q.push_back(cyc);
            lat_q.push_back(lat);
        end
        @(negedge clk_i);
        valid_i     = 1'b0;
        operand_x_i = '0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!(valid_o && ready_i) && n < 100) begin
            check("busy_ready_o", 32'(ready_o), 32'd0);
            @(negedge clk_i);
            n++;
        end
        check("handshake_seen", 32'(valid_o && ready_i), 32'd1);
        check("done_ready_o", 32'(ready_o), 32'd0);
        @(negedge clk_i);
        check("idle_valid_o", 32'(valid_o), 32'd0);
        check("idle_ready_o", 32'(ready_o), 32'd1);
    endtask

    logic [31:0] vec_x   [10] = '{32'h40400000, 32'hBFC00000, 32'h3F800001, 32'hFF800000,
                                  32'h7FC00001, 32'h80000000, 32'h00000001, 32'h7F000000,
                                  32'h1F800000, 32'h5F7FFFFF};
    logic [31:0] vec_exp [10] = '{32'h41100000, 32'h40100000, 32'h3F800002, 32'h7F800000,
                                  32'h7FC00000, 32'h00000000, 32'h00000000, 32'h7F800000,
                                  32'h00000000, 32'h7F7FFFFE};
    int          vec_lat [10] = '{26, 26, 26, 1, 1, 1, 1, 26, 26, 26};

    // Stimulus
    initial begin
        int n;
        repeat (3) @(negedge clk_i);
        check("rst_ready_o", 32'(ready_o), 32'd1);
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_result_o", result_o, 32'd0);
        rst_i = 1'b0;

        for (int i = 0; i < 10; i++) begin
            accept(vec_x[i], vec_exp[i], vec_lat[i]);
            wait_done();
        end

        // Backpressure: result must hold while ready_i is low
        ready_i = 1'b0;
        accept(32'h40400000, 32'h41100000, 26);
        n = 0;
        while (!valid_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("bp_valid_seen", 32'(valid_o), 32'd1);
        repeat (10) begin
            @(negedge clk_i);
            check("bp_result", result_o, 32'h41100000);
            check("bp_valid_o", 32'(valid_o), 32'd1);
            check("bp_ready_o", 32'(ready_o), 32'd0);
        end
        ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_release_valid_o", 32'(valid_o), 32'd0);
        check("bp_release_ready_o", 32'(ready_o), 32'd1);

        // Mid-operation reset aborts the operation
        accept(32'h40400000, 32'h41100000, 26);
        repeat (4) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("abort_valid_o", 32'(valid_o), 32'd0);
        check("abort_ready_o", 32'(ready_o), 32'd1);
        check("abort_result_o", result_o, 32'd0);
        if (exp_q.size() > 0) begin
            void'(exp_q.pop_back());
            void'(acc_q.pop_back());
            void'(lat_q.pop_back());
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        accept(32'h40000000, 32'h40800000, 26);
        wait_done();

        repeat (2) @(negedge clk_i);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ieee_square_iter.md
Name: ieee_square_iter

Overview:
- Multi-cycle IEEE 754 squarer (result = x*x); the inverse of the floating-point square-root path.
- Sits beside the sqrt unit in the FP library and serves as its round-trip check.
- Uses one iterative shift-add significand multiplier instead of a full array multiplier.
- Uses a valid/ready handshake on both sides, so latency is data-dependent: special operands bypass the multiplier.

Parameters:
- ExpWidth, 8: exponent field width.
- MantWidth, 23: stored fraction width, without the hidden bit.
- DataWidth, 1+ExpWidth+MantWidth: derived; do **not** overwrite.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- operand_x_i  in  DataWidth  IEEE operand; sampled on accept.
- valid_i  in  1  operand valid.
- ready_o  out  1  unit can accept; high only in IDLE.
- result_o  out  DataWidth  IEEE result; registered and stable while valid_o is high.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE, ready_o=1, valid_o=0, result_o=0, multiplier registers cleared.
  - Reset mid-operation aborts the operation; no result is produced.
- FSM states: IDLE, MUL, NORM, DONE.
- IDLE, on accept (valid_i & ready_o at edge E0):
  - Operand is classified and registered.
  - Special operand: result is written at E0, then DONE (valid_o high the cycle after E0, latency 1).
  - Otherwise: MUL, with a (MantWidth+1)-bit counter loaded.
- Special-case results (subnormals flush to zero, no subnormal outputs):
  - NaN in: canonical qNaN (exp all ones, fraction MSB=1, sign 0).
  - ±Inf in: +Inf.
  - ±0 or subnormal in: +0.
- MUL, one iteration per cycle:
  - sig = {1, frac}, MantWidth+1 bits; product register is 2*MantWidth+2 bits.
  - Radix-2 shift-add: examine one multiplier bit, conditionally add sig.
  - MantWidth+1 cycles, then NORM.
- NORM, one cycle:
  - Product lies in [1,4). If the top bit is set: shift right 1 and exp+1.
  - Unbiased exponent = 2*(e-bias) (+1 if shifted); computed in ExpWidth+2 bit signed arithmetic.
  - Rounding is round-to-nearest-even using guard bit plus OR-reduced sticky. A rounding carry-out renormalises and adds exp+1.
  - Biased exponent ≥ 2^ExpWidth-1 → +Inf. Biased exponent ≤ 0 → +0 (flush).
  - Sign is always 0.
  - Result is registered at the NORM edge, then DONE.
- Normal-path latency, accept edge to valid_o edge: MantWidth+3 cycles (26 for fp32).
- DONE:
  - valid_o=1; result_o is held constant.
  - On valid_o & ready_i → IDLE with valid_o=0; ready_o is high the next cycle. No same-cycle re-accept (ready_o=0 in DONE).
- Backpressure: while ready_i=0 in DONE, the unit stalls indefinitely with result_o unchanged.
- valid_i is ignored in MUL, NORM and DONE; an upstream operand stays pending until ready_o returns.

Test Plan:
- 0x40400000 (3.0), ready_i=1 → 0x41100000 (9.0); valid_o exactly 26 cycles after the accept edge; ready_o low from the accept edge until the handshake completes.
- 0xBFC00000 (-1.5) → 0x40100000 (2.25); 0x3F800001 → 0x3F800002 (rounds down; the discarded 2^-46 is below half-ulp).
- Specials, each with valid_o one cycle after accept:
  - 0xFF800000 → 0x7F800000.
  - 0x7FC00001 → 0x7FC00000.
  - 0x80000000 → 0x00000000.
  - 0x00000001 (subnormal) → 0x00000000.
- Range limits: 0x7F000000 (2^127) → 0x7F800000 (overflow to Inf); 0x1F800000 (2^-64) → 0x00000000 (underflow flush); 0x5F7FFFFF → 0x7F7FFFFE (top normal boundary, no overflow).
- Backpressure and reset:
  - Backpressure: hold ready_i=0 for 10 cycles after valid_o → result_o and valid_o stable, ready_o=0; release → one handshake, back to IDLE.
  - Mid-operation reset: assert rst_i at MUL cycle 5 → immediately valid_o=0, ready_o=1; after release, a fresh 2.0 (0x40000000) → 0x40800000 with full latency.
